// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: fetch controller state encodings and the NOP instruction constant
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2,
        FETCH_OUT  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch with stale-response drop and PC enable
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] NOP   = WIDTH'(NOP_INSTR)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc,
    input  logic             redirect,
    input  logic             stall_d,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic             mem_rvalid,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             pc_en,
    output logic             instr_valid,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc
);

    fetch_state_t     state, state_nxt;
    logic             drop, drop_nxt;
    logic             held;
    logic [WIDTH-1:0] addr_q;
    logic             capture, consume;

    // The first REQ cycle presents pc directly so a PC updated on the
    // preceding edge is fetched; later REQ cycles replay the captured copy.
    assign mem_req  = state == FETCH_REQ;
    assign mem_addr = (mem_req && !held) ? pc : addr_q;
    assign pc_en    = (state == FETCH_OUT && !stall_d) || redirect;

    // Next-state, drop-flag and output-buffer control decisions
    always_comb begin
        state_nxt = state;
        drop_nxt  = drop;
        capture   = 1'b0;
        consume   = 1'b0;
        case (state)
            FETCH_IDLE: state_nxt = FETCH_REQ;
            FETCH_REQ: begin
                drop_nxt  = drop | redirect;
                state_nxt = mem_ack ? FETCH_WAIT : FETCH_REQ;
            end
            FETCH_WAIT: begin
                drop_nxt  = mem_rvalid ? 1'b0 : (drop | redirect);
                capture   = mem_rvalid && !drop && !redirect;
                state_nxt = !mem_rvalid ? FETCH_WAIT : (capture ? FETCH_OUT : FETCH_REQ);
            end
            FETCH_OUT: begin
                consume   = redirect || !stall_d;
                state_nxt = consume ? FETCH_REQ : FETCH_OUT;
            end
            default: state_nxt = FETCH_IDLE;
        endcase
    end

    // FSM state, stale flag and the held request address
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= FETCH_IDLE;
            drop   <= 1'b0;
            held   <= 1'b0;
            addr_q <= '0;
        end else begin
            state <= state_nxt;
            drop  <= drop_nxt;
            held  <= mem_req && !mem_ack;
            if (mem_req)
                addr_q <= mem_addr;
        end
    end

    // Output buffer: load on a live response, return to NOP when consumed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_valid <= 1'b0;
            instr       <= NOP;
            instr_pc    <= '0;
        end else if (capture) begin
            instr_valid <= 1'b1;
            instr       <= mem_rdata;
            instr_pc    <= mem_addr;
        end else if (consume) begin
            instr_valid <= 1'b0;
            instr       <= NOP;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: vector table, directed corner sequences and random traffic against a transaction model
module tb_fetch_ctrl;

    localparam logic [31:0] NOPV = 32'h0000_0013;

    logic        clk, reset, redirect, stall_d, mem_ack, mem_rvalid;
    logic [31:0] pc, mem_rdata, tgt;
    logic        mem_req, pc_en, instr_valid;
    logic [31:0] mem_addr, instr, instr_pc;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_ctrl dut (
        .clk(clk), .reset(reset), .pc(pc), .redirect(redirect), .stall_d(stall_d),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .pc_en(pc_en),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // transaction-level reference: pending request, outstanding fetch, held instruction
    logic        boot, e_req, r_first, r_stale, has_out, o_stale, e_valid;
    logic [31:0] r_addr, o_addr, e_instr, e_ipc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        boot = 1'b1; e_req = 1'b0; r_first = 1'b0; r_stale = 1'b0; r_addr = '0;
        has_out = 1'b0; o_stale = 1'b0; o_addr = '0;
        e_valid = 1'b0; e_instr = NOPV; e_ipc = '0;
        pc = '0;
    endtask

    task automatic start_req();
        e_req = 1'b1; r_first = 1'b1; r_stale = 1'b0;
    endtask

    task automatic model_check();
        chk("req", mem_req, e_req);
        if (e_req) chk("addr", mem_addr, r_first ? pc : r_addr);
        chk("pc_en", pc_en, redirect || (e_valid && !stall_d));
        chk("valid", instr_valid, e_valid);
        chk("instr", instr, e_valid ? e_instr : NOPV);
        if (e_valid) chk("instr_pc", instr_pc, e_ipc);
    endtask

    task automatic model_update();
        logic        pcen, st;
        logic [31:0] a;
        pcen = redirect || (e_valid && !stall_d);
        if (boot) begin
            boot = 1'b0;
            start_req();
        end else if (e_req) begin
            a  = r_first ? pc : r_addr;
            st = r_stale | redirect;
            if (mem_ack) begin
                e_req = 1'b0; has_out = 1'b1; o_addr = a; o_stale = st;
            end else begin
                r_first = 1'b0; r_addr = a; r_stale = st;
            end
        end else if (has_out) begin
            st = o_stale | redirect;
            if (mem_rvalid) begin
                has_out = 1'b0;
                if (st) start_req();
                else begin
                    e_valid = 1'b1; e_instr = mem_rdata; e_ipc = o_addr;
                end
            end else o_stale = st;
        end else if (e_valid && (redirect || !stall_d)) begin
            e_valid = 1'b0;
            start_req();
        end
        if (pcen) pc = redirect ? tgt : pc + 32'd4;
    endtask

    task automatic step();
        #1;
        model_check();
        @(posedge clk);
        #1;
        model_update();
    endtask

    task automatic drive(input logic r, input logic s, input logic a, input logic v,
                         input logic [31:0] d, input logic [31:0] t);
        redirect = r; stall_d = s; mem_ack = a; mem_rvalid = v; mem_rdata = d; tgt = t;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"}, mem_req, 1'b0);
        chk({tag, "_addr"}, mem_addr, 32'h0);
        chk({tag, "_valid"}, instr_valid, 1'b0);
        chk({tag, "_instr"}, instr, NOPV);
        chk({tag, "_ipc"}, instr_pc, 32'h0);
        chk({tag, "_pcen"}, pc_en, 1'b0);
    endtask

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    typedef struct {
        logic        ack, rvalid;
        logic [31:0] rdata;
        logic        e_req, e_pcen, e_valid;
        logic [31:0] e_addr, e_instr, e_ipc;
    } vec_t;

    vec_t v[10];

    initial begin
        // zero-wait memory, pc 0,4,8: IDLE then three REQ/WAIT/OUT rounds
        v[0] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0, NOPV,          32'h0};
        v[1] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0, NOPV,          32'h0};
        v[2] = '{1'b0, 1'b1, 32'h1111_0000, 1'b0, 1'b0, 1'b0, 32'h0, NOPV,          32'h0};
        v[3] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0, 32'h1111_0000, 32'h0};
        v[4] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h4, NOPV,          32'h0};
        v[5] = '{1'b0, 1'b1, 32'h2222_0004, 1'b0, 1'b0, 1'b0, 32'h0, NOPV,          32'h0};
        v[6] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0, 32'h2222_0004, 32'h4};
        v[7] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h8, NOPV,          32'h0};
        v[8] = '{1'b0, 1'b1, 32'h3333_0008, 1'b0, 1'b0, 1'b0, 32'h0, NOPV,          32'h0};
        v[9] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0, 32'h3333_0008, 32'h8};

        // reset held with a spurious response on the bus
        model_reset();
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'hBAD0_BAD0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_reset_vals("rst");
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, v[i].ack, v[i].rvalid, v[i].rdata, 32'h0);
            #1;
            chk("tbl_req", mem_req, v[i].e_req);
            if (v[i].e_req) chk("tbl_addr", mem_addr, v[i].e_addr);
            chk("tbl_pcen", pc_en, v[i].e_pcen);
            chk("tbl_valid", instr_valid, v[i].e_valid);
            chk("tbl_instr", instr, v[i].e_instr);
            if (v[i].e_valid) chk("tbl_ipc", instr_pc, v[i].e_ipc);
            step();
        end

        // slow memory: ack on the third REQ cycle, rvalid on the third WAIT cycle
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, i == 2, 1'b0, 32'h0, 32'h0);
            #1;
            chk("slow_req", mem_req, 1'b1);
            chk("slow_addr", mem_addr, 32'hC);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); step();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0);
        #1;
        chk("slow_valid_rv", instr_valid, 1'b0);
        step();

        // decode stall for four cycles holds the instruction
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
            #1;
            chk("stall_valid", instr_valid, 1'b1);
            chk("stall_instr", instr, 32'hDEAD_BEEF);
            chk("stall_ipc", instr_pc, 32'hC);
            chk("stall_pcen", pc_en, 1'b0);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("unstall_pcen", pc_en, 1'b1);
        step();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        #1;
        chk("consumed_valid", instr_valid, 1'b0);
        chk("consumed_addr", mem_addr, 32'h10);
        step();

        // redirect in WAIT: the following response is stale
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h100);
        #1;
        chk("redir_wait_pcen", pc_en, 1'b1);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hAAAA_AAAA, 32'h0); step();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        #1;
        chk("drop_valid", instr_valid, 1'b0);
        chk("drop_req", mem_req, 1'b1);
        chk("redir_addr", mem_addr, 32'h100);
        step();

        // redirect together with rvalid in WAIT
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h1111_1111, 32'h200); step();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        #1;
        chk("same_valid", instr_valid, 1'b0);
        chk("same_req", mem_req, 1'b1);
        chk("same_addr", mem_addr, 32'h200);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h2222_2222, 32'h0); step();

        // redirect in OUT overrides stall
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h300);
        #1;
        chk("out_redir_valid", instr_valid, 1'b1);
        chk("out_redir_pcen", pc_en, 1'b1);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("out_redir_clr", instr_valid, 1'b0);
        chk("out_redir_addr", mem_addr, 32'h300);
        step();

        // random traffic with one asynchronous reset mid-run
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                reset = 1'b0;
                #2;
                chk_reset_vals("async");
                model_reset();
                @(posedge clk);
                #1;
                reset = 1'b1;
            end
            redirect   = ($urandom % 10) == 0;
            tgt        = $urandom & 32'h0000_FFFC;
            stall_d    = ($urandom % 3) == 0;
            mem_ack    = e_req && ($urandom % 2 == 1);
            mem_rvalid = has_out ? ($urandom % 3 == 0) : ($urandom % 8 == 0);
            mem_rdata  = has_out ? memfn(o_addr) : $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
